cpu_oci_dct_packer: RTL and testbench

CPU_OCI_DCT_PACKER -- requirements
Module: cpu_oci_dct_packer

---
 rtl/cpu_oci_pkg.sv | 13 +
 rtl/cpu_oci_dct_outreg.sv | 57 +++++
 rtl/cpu_oci_dct_packer.sv | 122 ++++++++++++
 tb/tb_cpu_oci_dct_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_oci_pkg.sv
// Shared sizing constants for the OCI trace DCT packer.
package cpu_oci_pkg;

    // Width of one trace atom in bits
    localparam int ATOM_W          = 2;
    // Number of atoms that make up a full frame
    localparam int ATOMS_PER_FRAME = 15;
    // Packed frame width
    localparam int DCT_W           = ATOM_W * ATOMS_PER_FRAME;
    // Counter width able to hold 0..ATOMS_PER_FRAME
    localparam int CNT_W           = $clog2(ATOMS_PER_FRAME + 1);

endpackage

// File: rtl/cpu_oci_dct_outreg.sv
// Valid/ready holding register for one packed trace frame.
// Once loaded, the frame stays stable until the consumer takes it.
module cpu_oci_dct_outreg #(
    parameter int BUF_W    = cpu_oci_pkg::DCT_W,
    parameter int CNT_BITS = cpu_oci_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [BUF_W-1:0]    load_buf,
    input  logic [CNT_BITS-1:0] load_cnt,
    input  logic                frame_ready,
    output logic [BUF_W-1:0]    frame_buf,
    output logic [CNT_BITS-1:0] frame_cnt,
    output logic                frame_valid,
    output logic                free
);

    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;

    // The register can take a new frame when empty or when it drains this cycle
    assign free = !valid_q || frame_ready;

    // Next state: a load wins over a drain on the same edge
    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            buf_d   = load_buf;
            cnt_d   = load_cnt;
            valid_d = 1'b1;
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending frame without a handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign frame_buf   = buf_q;
    assign frame_cnt   = cnt_q;
    assign frame_valid = valid_q;

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// Packs a stream of trace atoms into fixed-width frames.
// An accumulator fills while a separate output register holds the
// previous frame, so the stream only stalls when both are full.
module cpu_oci_dct_packer #(
    parameter int ATOM_W          = cpu_oci_pkg::ATOM_W,
    parameter int ATOMS_PER_FRAME = cpu_oci_pkg::ATOMS_PER_FRAME
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   atom_valid,
    input  logic [ATOM_W-1:0]                      atom,
    output logic                                   atom_ready,
    input  logic                                   flush,
    input  logic                                   test_ending,
    output logic [ATOM_W*ATOMS_PER_FRAME-1:0]      dct_buffer,
    output logic [$clog2(ATOMS_PER_FRAME+1)-1:0]   dct_count,
    output logic                                   frame_valid,
    input  logic                                   frame_ready,
    output logic                                   test_has_ended
);

    localparam int DCT_W = ATOM_W * ATOMS_PER_FRAME;
    localparam int CNT_W = $clog2(ATOMS_PER_FRAME + 1);

    logic [DCT_W-1:0] acc_buf_q, acc_buf_d, ins_buf;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, launch_cnt;
    logic             flush_pend_q, flush_pend_d;
    logic             ended_seen_q, ended_seen_d;
    logic             has_ended_q, has_ended_d;

    logic accept, acc_full, sum_full, sum_nonzero;
    logic end_first, flush_req, want_launch, out_free, launch, carry;

    // Accumulator state qualifiers
    assign acc_full    = (int'(acc_cnt_q) == ATOMS_PER_FRAME);
    assign atom_ready  = !ended_seen_q && !(acc_full && frame_valid && !frame_ready);
    assign accept      = atom_valid && atom_ready;
    assign sum_full    = (int'(acc_cnt_q) + int'(accept) == ATOMS_PER_FRAME);
    assign sum_nonzero = (acc_cnt_q != '0) || accept;

    // A full accumulator can only accept when the output frees up, so that
    // atom rolls over into slot 0 of the next accumulator.
    assign carry = acc_full && accept;

    // The first cycle test_ending is seen behaves like a flush
    assign end_first   = test_ending && !ended_seen_q;
    assign flush_req   = flush || end_first;
    assign want_launch = acc_full || sum_full || ((flush_req || flush_pend_q) && sum_nonzero);
    assign launch      = want_launch && out_free;

    // Accumulator contents with this cycle's accepted atom already inserted
    generate
        for (genvar gi = 0; gi < ATOMS_PER_FRAME; gi++) begin : g_slot
            assign ins_buf[gi*ATOM_W +: ATOM_W] =
                (accept && (acc_cnt_q == CNT_W'(gi))) ? atom
                                                      : acc_buf_q[gi*ATOM_W +: ATOM_W];
        end
    endgenerate

    assign launch_cnt = acc_full ? acc_cnt_q : acc_cnt_q + {{(CNT_W-1){1'b0}}, accept};

    // Next state for accumulator, pending flush and end-of-test tracking
    always_comb begin
        acc_buf_d    = acc_buf_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        ended_seen_d = ended_seen_q || test_ending;
        has_ended_d  = has_ended_q ||
                       (ended_seen_q && (acc_cnt_q == '0) && !flush_pend_q && !frame_valid);
        if (launch) begin
            flush_pend_d = 1'b0;
            acc_buf_d    = '0;
            acc_cnt_d    = '0;
            if (carry) begin
                acc_buf_d[ATOM_W-1:0] = atom;
                acc_cnt_d             = {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_buf_d = ins_buf;
            acc_cnt_d = launch_cnt;
            if (flush_req && sum_nonzero) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // Accumulator and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            ended_seen_q <= 1'b0;
            has_ended_q  <= 1'b0;
        end else begin
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            ended_seen_q <= ended_seen_d;
            has_ended_q  <= has_ended_d;
        end
    end

    assign test_has_ended = has_ended_q;

    cpu_oci_dct_outreg #(
        .BUF_W    (DCT_W),
        .CNT_BITS (CNT_W)
    ) u_outreg (
        .clk         (clk),
        .reset       (reset),
        .load        (launch),
        .load_buf    (ins_buf),
        .load_cnt    (launch_cnt),
        .frame_ready (frame_ready),
        .frame_buf   (dct_buffer),
        .frame_cnt   (dct_count),
        .frame_valid (frame_valid),
        .free        (out_free)
    );

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed bench for the trace DCT packer.
module tb_cpu_oci_dct_packer;

    localparam int AW = cpu_oci_pkg::ATOM_W;
    localparam int DW = cpu_oci_pkg::DCT_W;
    localparam int CW = cpu_oci_pkg::CNT_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          atom_valid = 1'b0;
    logic [AW-1:0] atom = '0;
    logic          flush = 1'b0;
    logic          test_ending = 1'b0;
    logic          frame_ready = 1'b0;
    logic          atom_ready;
    logic [DW-1:0] dct_buffer;
    logic [CW-1:0] dct_count;
    logic          frame_valid;
    logic          test_has_ended;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .test_has_ended (test_has_ended)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_fv", frame_valid, 0);
        chk("rst_buf", dct_buffer, 0);
        chk("rst_cnt", dct_count, 0);
        chk("rst_ended", test_has_ended, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", atom_ready, 1);

        // ---------------- full frame, back-to-back ----------------
        // atoms 0,1,2,3 repeat; atoms 12..14 are 0,1,2 -> top six bits 6'h24
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1;
            atom = AW'(i % 4);
            #1;
            chk("a_ready", atom_ready, 1);
            if (i == 14) chk("a_fv_early", frame_valid, 0);
            tick();
        end
        atom_valid = 1'b0;
        chk("a_fv", frame_valid, 1);
        chk("a_cnt", dct_count, 15);
        chk("a_buf", dct_buffer, 32'h24E4_E4E4);
        tick();
        chk("a_fv_drop", frame_valid, 0);

        // ---------------- partial frame via flush ----------------
        for (int i = 0; i < 3; i++) begin
            atom_valid = 1'b1;
            atom = AW'(i + 1);
            tick();
        end
        atom_valid = 1'b0;
        chk("b_fv_pre", frame_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("b_fv", frame_valid, 1);
        chk("b_cnt", dct_count, 3);
        chk("b_buf", dct_buffer, 32'h0000_0039);
        tick();
        chk("b_fv_drop", frame_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("b_empty_fl", frame_valid, 0);
        tick();
        chk("b_empty_fl2", frame_valid, 0);

        // ---------------- backpressure: 30 atoms held ----------------
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            atom_valid = 1'b1;
            atom = (i < 15) ? AW'(3) : AW'((i - 15) % 4);
            #1;
            chk("c_ready", atom_ready, 1);
            tick();
        end
        atom = '0;
        #1;
        chk("c_stall", atom_ready, 0);
        tick();
        chk("c_stall2", atom_ready, 0);
        chk("c_fv1", frame_valid, 1);
        chk("c_cnt1", dct_count, 15);
        chk("c_buf1", dct_buffer, 32'h3FFF_FFFF);
        atom_valid = 1'b0;
        frame_ready = 1'b1;
        tick();
        chk("c_fv2", frame_valid, 1);
        chk("c_cnt2", dct_count, 15);
        chk("c_buf2", dct_buffer, 32'h24E4_E4E4);
        tick();
        chk("c_fv_drop", frame_valid, 0);

        // ---------------- flush together with 15th atom ----------------
        // 14 atoms of 2 then a final 1 -> 30'h1AAA_AAAA
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1;
            atom = (i == 14) ? AW'(1) : AW'(2);
            flush = (i == 14);
            tick();
        end
        atom_valid = 1'b0;
        flush = 1'b0;
        chk("d_fv", frame_valid, 1);
        chk("d_cnt", dct_count, 15);
        chk("d_buf", dct_buffer, 32'h1AAA_AAAA);
        tick();
        chk("d_no_empty", frame_valid, 0);
        tick();
        chk("d_no_empty2", frame_valid, 0);

        // ---------------- reset mid-stream ----------------
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            atom_valid = 1'b1;
            atom = (i < 15) ? AW'(1) : AW'(2);
            tick();
        end
        atom_valid = 1'b0;
        chk("e_fv_pre", frame_valid, 1);
        reset = 1'b1;
        tick();
        chk("e_fv", frame_valid, 0);
        chk("e_buf", dct_buffer, 0);
        chk("e_cnt", dct_count, 0);
        reset = 1'b0;
        tick();
        chk("e_ready", atom_ready, 1);
        frame_ready = 1'b1;
        atom_valid = 1'b1;
        atom = AW'(3);
        tick();
        atom_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("e_fv_new", frame_valid, 1);
        chk("e_cnt_new", dct_count, 1);
        chk("e_buf_new", dct_buffer, 32'h0000_0003);
        tick();

        // ---------------- end of test ----------------
        // atoms 1,2,3,0,1 -> 30'h139
        for (int i = 0; i < 5; i++) begin
            atom_valid = 1'b1;
            atom = AW'((i + 1) % 4);
            tick();
        end
        atom_valid = 1'b0;
        test_ending = 1'b1;
        tick();
        chk("f_fv", frame_valid, 1);
        chk("f_cnt", dct_count, 5);
        chk("f_buf", dct_buffer, 32'h0000_0139);
        chk("f_ready", atom_ready, 0);
        chk("f_ended_early", test_has_ended, 0);
        atom_valid = 1'b1;
        tick();
        chk("f_fv_drop", frame_valid, 0);
        chk("f_ready2", atom_ready, 0);
        chk("f_ended_wait", test_has_ended, 0);
        tick();
        chk("f_ended", test_has_ended, 1);
        test_ending = 1'b0;
        tick();
        tick();
        chk("f_ended_stky", test_has_ended, 1);
        chk("f_no_frame", frame_valid, 0);
        atom_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
